eth_frame_assembler: RTL
========================

# eth_frame_assembler

Collects the received Ethernet byte stream from the MAC receive interface into the parallel `eth_frame` vector consumed by `udp_main`, then pulses `frame_start` for one cycle once a complete, error-free frame is in place. Sits directly upstream of `udp_main`. Drops runt, oversize and errored frames and counts the drops.

## Interface
- `FRAME_WIDTH`, 12000: width of `eth_frame` in bits; multiple of 16; MAX_BYTES = FRAME_WIDTH/8 (1500 at default).
- `MIN_BYTES`, 14: shortest accepted frame in bytes (Ethernet header).
- `main_clk` in 1: single clock; every register is in this domain.
- `main_rst_n` in 1: reset, asynchronous assert, active-low.
- `rx_data` in 8: received byte, in wire order.
- `rx_valid` in 1: `rx_data` carries a byte this cycle. No backpressure; every valid byte is consumed.
- `rx_last` in 1: the current byte is the last of the frame. Ignored unless `rx_valid`=1.
- `rx_err` in 1: frame is bad (FCS/PHY error). Sampled only with `rx_valid && rx_last`.
- `eth_frame` out FRAME_WIDTH: assembled frame.
- `frame_len` out $clog2(MAX_BYTES+1): byte count of the frame in `eth_frame`.
- `frame_start` out 1: one-cycle pulse; `eth_frame` and `frame_len` are valid.
- `drop_count` out 16: frames dropped since reset; saturates at 16'hFFFF.

## Operation
- Byte placement: byte i (0 = first on wire) is written at bit offset 8*(i XOR 1). Each network-order 16-bit word k occupies [16k+15:16k], with its first byte in the upper half. Ethertype (bytes 12,13) therefore lands on [111:96]; 0x0800 gives `eth_frame[111:96]`=16'h0800.
- The first byte of a frame zeroes the whole buffer in the same edge that writes byte 0, so bytes beyond `frame_len` always read 0.
- States:
  - IDLE: the first valid byte writes byte 0 and sets count=1.
    - With `rx_last` also set, the frame is a runt: drop, stay in IDLE.
    - Otherwise go to RECV.
  - RECV: each valid byte writes at index count, then count++.
    - On `rx_last`, the completed frame is accepted only if `rx_err`=0 and count+1 >= MIN_BYTES. Accept: `frame_len`<=count+1 and pulse `frame_start`. Otherwise drop. Either way go to IDLE.
    - A valid byte arriving when count == MAX_BYTES (overflow) is not written. Drop is counted once and the block goes to DROP; a byte with `rx_last` at this point counts the drop and returns to IDLE.
  - DROP: discard bytes until `rx_valid && rx_last`, then go to IDLE. No further count increment.
- A drop leaves `frame_len` unchanged and produces no `frame_start`. `eth_frame` holds partial or garbage content, which is legal because it is not qualified by `frame_start`.
- `drop_count` increments by exactly 1 per dropped frame and saturates.

## Timing
- Reset values: `eth_frame`=0, `frame_len`=0, `frame_start`=0, `drop_count`=0, state IDLE, count 0.
- Latency: last byte sampled at edge N, then `frame_start`=1 for cycle N..N+1 only.
- `eth_frame` and `frame_len` are stable for the entire `frame_start` cycle, including when the next frame's byte 0 arrives in that same cycle: that byte takes effect only at the following edge. Zero inter-frame gap is supported.
- Reset asserted mid-frame: state returns to IDLE immediately. The partial frame is discarded and not counted. No `frame_start` is produced.
- `rx_last` or `rx_err` without `rx_valid`: no effect.

## Structure
- Package `eth_pkg`:
  - state enum `asm_state_t` {IDLE, RECV, DROP};
  - `ETH_HDR_BYTES`=14;
  - `ETHERTYPE_IPV4`=16'h0800 and `ETHERTYPE_ARP`=16'h0806 (shared with `udp_main`);
  - function `byte_bit_offset(i)` implementing 8*(i XOR 1).
- Single module; no sub-module. The write decoder is a generate loop over MAX_BYTES byte lanes, each enabled by count == lane.

## Test plan
- 60-byte frame: dest FF×6, src 02:00:00:00:00:01, ethertype 08 00, payload 0x00..0x2D.
  - `frame_start` pulses once, 1 cycle after last byte.
  - `eth_frame[111:96]`=16'h0800, `eth_frame[15:0]`=16'hFFFF, `frame_len`=60.
  - Bits above 480 are zero.
- Back-to-back: an IPv4 frame, then byte 0 of an ARP frame (ethertype 08 06) in the `frame_start` cycle.
  - First pulse sees [111:96]=16'h0800.
  - Second pulse sees 16'h0806.
- Runt of 10 bytes, then an errored 64-byte frame (`rx_err`=1 on last): no `frame_start` for either; `drop_count`=2.
- Oversize: with FRAME_WIDTH=256 (32 bytes), send a 40-byte frame then a 20-byte frame.
  - First frame: one drop, no pulse.
  - Second frame: accepted, `frame_len`=20.
- Exact boundaries, with FRAME_WIDTH=256:
  - 32-byte frame: accepted with `frame_len`=32.
  - 14-byte frame: accepted.
  - 13-byte frame: dropped.
- Reset mid-frame: after byte 20 of 60, pulse `main_rst_n` low for 1 ns between edges.
  - All outputs go to 0 asynchronously; `drop_count` stays 0.
  - The next full frame is assembled correctly.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared Ethernet definitions for the receive-side frame assembler and udp_main.
package eth_pkg;

  typedef enum logic [1:0] {IDLE, RECV, DROP} asm_state_t;

  localparam int          ETH_HDR_BYTES  = 14;
  localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

  // Wire byte i lands so that each 16-bit word is in network order (first byte high).
  function automatic int unsigned byte_bit_offset(input int unsigned i);
    return 8 * (i ^ 1);
  endfunction

endpackage

// File: rtl/eth_frame_assembler.sv
// Assembles the MAC receive byte stream into a parallel frame vector for udp_main,
// dropping runt, oversize and errored frames and counting the drops.
module eth_frame_assembler
  import eth_pkg::*;
#(
  parameter  int FRAME_WIDTH = 12000,
  parameter  int MIN_BYTES   = ETH_HDR_BYTES,
  localparam int MAX_BYTES   = FRAME_WIDTH / 8,
  localparam int LEN_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic                   main_clk,
  input  logic                   main_rst_n,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_last,
  input  logic                   rx_err,
  output logic [FRAME_WIDTH-1:0] eth_frame,
  output logic [LEN_W-1:0]       frame_len,
  output logic                   frame_start,
  output logic [15:0]            drop_count
);

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_BYTES);
  localparam logic [LEN_W-1:0] MIN_CNT = LEN_W'(MIN_BYTES);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  asm_state_t             r_state;
  logic [LEN_W-1:0]       r_count;
  logic [LEN_W-1:0]       r_frame_len;
  logic                   r_frame_start;
  logic [15:0]            r_drop_count;

  logic                   w_first;
  logic                   w_wr;
  logic [LEN_W-1:0]       w_cnt_inc;
  logic                   w_len_ok;
  logic [FRAME_WIDTH-1:0] w_frame;

  assign w_first   = rx_valid && (r_state == IDLE);
  assign w_wr      = rx_valid && (r_state == RECV) && (r_count != MAX_CNT);
  assign w_cnt_inc = r_count + LEN_W'(1);
  assign w_len_ok  = (w_cnt_inc >= MIN_CNT);

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_frame_len   <= '0;
      r_frame_start <= 1'b0;
      r_drop_count  <= '0;
    end else begin
      r_frame_start <= 1'b0;
      if (rx_valid) begin
        case (r_state)
          IDLE: begin
            r_count <= LEN_W'(1);
            if (rx_last) r_drop_count <= sat_inc(r_drop_count);
            else         r_state      <= RECV;
          end
          RECV: begin
            if (r_count == MAX_CNT) begin
              // Overflow byte: counted once here, the rest of the frame is swallowed in DROP.
              r_drop_count <= sat_inc(r_drop_count);
              r_state      <= rx_last ? IDLE : DROP;
            end else if (rx_last) begin
              r_state <= IDLE;
              if (!rx_err && w_len_ok) begin
                r_frame_len   <= w_cnt_inc;
                r_frame_start <= 1'b1;
              end else begin
                r_drop_count <= sat_inc(r_drop_count);
              end
            end else begin
              r_count <= w_cnt_inc;
            end
          end
          DROP: if (rx_last) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // One byte lane per frame byte; byte 0 of a new frame also clears every other lane.
  for (genvar lane = 0; lane < MAX_BYTES; lane++) begin : g_lane
    localparam int unsigned OFF        = byte_bit_offset(lane);
    localparam logic [7:0]  FIRST_MASK = (lane == 0) ? 8'hFF : 8'h00;
    logic [7:0] r_byte;

    always_ff @(posedge main_clk or negedge main_rst_n) begin
      if (!main_rst_n)                              r_byte <= '0;
      else if (w_first)                             r_byte <= rx_data & FIRST_MASK;
      else if (w_wr && (r_count == LEN_W'(lane)))   r_byte <= rx_data;
    end

    assign w_frame[OFF +: 8] = r_byte;
  end

  assign eth_frame   = w_frame;
  assign frame_len   = r_frame_len;
  assign frame_start = r_frame_start;
  assign drop_count  = r_drop_count;

endmodule
